// File: rtl/e_rx_pkt_reader.sv
// MAC RX packet reader: drains the MAC RX interface into a 4-entry FWFT FIFO, streams packets out,
// and reports per-packet length/status plus good/bad counters. E_RX_TIMEOUT_EN adds an RD watchdog.
module e_rx_pkt_reader #(
    parameter int unsigned MIN_PKT_BYTES = 64,
    parameter int unsigned MAX_PKT_BYTES = 1518,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned TIMEOUT_CYC   = 256
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_err,
    input  logic [2:0]       pkt_rx_mod,
    output logic [63:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [2:0]       out_mod,
    output logic             out_val,
    input  logic             out_ready,
    output logic [15:0]      pkt_len,
    output logic [3:0]       pkt_status,
    output logic             pkt_len_val,
    output logic [CNT_W-1:0] good_pkt_cnt,
    output logic [CNT_W-1:0] bad_pkt_cnt
);

    localparam logic [15:0] MinLen = 16'(MIN_PKT_BYTES);
    localparam logic [15:0] MaxLen = 16'(MAX_PKT_BYTES);

`ifdef E_RX_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StRd, StGap, StAbort} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRd, StGap} state_e;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } entry_t;

    state_e state_q, state_d;
    logic   ren_d1_q;

    entry_t     mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] fifo_cnt_q;
    logic       fifo_empty, fifo_full, push, pop, wr;
    entry_t     push_entry, head;

    logic        first_q, frm_q;
    logic [15:0] len_q;
    logic        cap, cap_eop, frm_new, size_err_new, eop_err;
    logic [15:0] word_bytes, len_new;
    logic [16:0] len_sum;

    logic        rpt_fire, rpt_bad;
    logic [15:0] rpt_len;
    logic [3:0]  rpt_status;
    logic        wd_hit;

    logic [15:0]      pkt_len_q;
    logic [3:0]       pkt_status_q;
    logic             pkt_len_val_q;
    logic [CNT_W-1:0] good_q, bad_q;

    // Capture and per-packet accounting
    assign cap     = (state_q == StRd) && pkt_rx_val;
    assign cap_eop = cap && pkt_rx_eop;

    assign word_bytes   = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {13'd0, pkt_rx_mod} : 16'd8;
    assign len_sum      = (first_q ? 17'd0 : {1'b0, len_q}) + {1'b0, word_bytes};
    assign len_new      = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign frm_new      = first_q ? !pkt_rx_sop : (frm_q | pkt_rx_sop);
    assign size_err_new = (len_new < MinLen) || (len_new > MaxLen);
    assign eop_err      = pkt_rx_err | frm_new | size_err_new;

`ifdef E_RX_TIMEOUT_EN
    localparam int unsigned     WdW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC);

    logic [WdW-1:0] wd_q;
    logic           abort_push, abort_frm, abort_size;
    logic [15:0]    abort_len;

    assign wd_hit = (state_q == StRd) && (wd_q == WdLimit);

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            wd_q <= '0;
        end else if ((state_q != StRd) || pkt_rx_val) begin
            wd_q <= '0;
        end else if (wd_q != WdLimit) begin
            wd_q <= wd_q + WdW'(1);
        end
    end

    // The terminator reports whatever bytes were captured before the stall.
    assign abort_push = (state_q == StAbort) && !fifo_full;
    assign abort_len  = first_q ? 16'd0 : len_q;
    assign abort_frm  = !first_q && frm_q;
    assign abort_size = (abort_len < MinLen) || (abort_len > MaxLen);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        push       = cap;
        push_entry = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop, mod: pkt_rx_mod,
                       err: cap_eop & eop_err};
        rpt_fire   = cap_eop;
        rpt_len    = len_new;
        rpt_status = {1'b0, frm_new, size_err_new, pkt_rx_err};
        rpt_bad    = eop_err;
`ifdef E_RX_TIMEOUT_EN
        if (abort_push) begin
            push       = 1'b1;
            push_entry = '{data: 64'd0, sop: 1'b0, eop: 1'b1, mod: 3'd0, err: 1'b1};
            rpt_fire   = 1'b1;
            rpt_len    = abort_len;
            rpt_status = {1'b1, abort_frm, abort_size, 1'b0};
            rpt_bad    = 1'b1;
        end
`endif
    end

    // Read enable keeps at most one word in flight and headroom in the FIFO
    assign pkt_rx_ren = (state_q == StRd) && !(pkt_rx_val && pkt_rx_eop) && !wd_hit &&
                        (({1'b0, fifo_cnt_q} + {3'b000, ren_d1_q}) <= 4'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (pkt_rx_avail) state_d = StRd;
            StRd: begin
                if (pkt_rx_val && pkt_rx_eop) begin
                    state_d = StGap;
                end else if (wd_hit) begin
`ifdef E_RX_TIMEOUT_EN
                    state_d = StAbort;
`endif
                end
            end
            StGap: state_d = StIdle;
`ifdef E_RX_TIMEOUT_EN
            StAbort: if (!fifo_full) state_d = StGap;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q  <= StIdle;
            ren_d1_q <= 1'b0;
            first_q  <= 1'b1;
            frm_q    <= 1'b0;
            len_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            ren_d1_q <= pkt_rx_ren;
            if (state_q == StIdle) begin
                first_q <= 1'b1;
            end else if (cap) begin
                first_q <= 1'b0;
                frm_q   <= frm_new;
                len_q   <= len_new;
            end
        end
    end

    // FIFO: first-word-fall-through, outputs forced to zero while empty
    assign fifo_empty = (fifo_cnt_q == 3'd0);
    assign fifo_full  = (fifo_cnt_q == 3'd4);
    assign pop        = !fifo_empty && out_ready;
    assign wr         = push && (!fifo_full || pop);

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
        end else begin
            if (wr)  wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            fifo_cnt_q <= fifo_cnt_q + {2'b00, wr} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (wr) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head     = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign out_val  = !fifo_empty;
    assign out_data = head.data;
    assign out_sop  = head.sop;
    assign out_eop  = head.eop;
    assign out_mod  = head.mod;
    assign out_err  = head.err;

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_len_q     <= 16'd0;
            pkt_status_q  <= 4'd0;
            pkt_len_val_q <= 1'b0;
            good_q        <= '0;
            bad_q         <= '0;
        end else begin
            pkt_len_val_q <= rpt_fire;
            if (rpt_fire) begin
                pkt_len_q    <= rpt_len;
                pkt_status_q <= rpt_status;
                if (rpt_bad) begin
                    if (bad_q != '1) bad_q <= bad_q + CNT_W'(1);
                end else begin
                    if (good_q != '1) good_q <= good_q + CNT_W'(1);
                end
            end
        end
    end

    assign pkt_len      = pkt_len_q;
    assign pkt_status   = pkt_status_q;
    assign pkt_len_val  = pkt_len_val_q;
    assign good_pkt_cnt = good_q;
    assign bad_pkt_cnt  = bad_q;

endmodule

// File: tb/tb_e_rx_pkt_reader.sv
// Directed bench for e_rx_pkt_reader: MAC responder model, output and report scoreboards.
`timescale 1ns/1ps
module tb_e_rx_pkt_reader;

    localparam int unsigned CNT_W = 32;

    logic             clk_156m25 = 1'b0;
    logic             reset_156m25;
    logic             pkt_rx_avail;
    logic             pkt_rx_ren;
    logic [63:0]      pkt_rx_data;
    logic             pkt_rx_sop, pkt_rx_eop, pkt_rx_val, pkt_rx_err;
    logic [2:0]       pkt_rx_mod;
    logic [63:0]      out_data;
    logic             out_sop, out_eop, out_err, out_val, out_ready;
    logic [2:0]       out_mod;
    logic [15:0]      pkt_len;
    logic [3:0]       pkt_status;
    logic             pkt_len_val;
    logic [CNT_W-1:0] good_pkt_cnt, bad_pkt_cnt;

    e_rx_pkt_reader #(
        .MIN_PKT_BYTES(64),
        .MAX_PKT_BYTES(1518),
        .CNT_W        (CNT_W),
        .TIMEOUT_CYC  (256)
    ) dut (
        .clk_156m25  (clk_156m25),
        .reset_156m25(reset_156m25),
        .pkt_rx_avail(pkt_rx_avail),
        .pkt_rx_ren  (pkt_rx_ren),
        .pkt_rx_data (pkt_rx_data),
        .pkt_rx_sop  (pkt_rx_sop),
        .pkt_rx_eop  (pkt_rx_eop),
        .pkt_rx_val  (pkt_rx_val),
        .pkt_rx_err  (pkt_rx_err),
        .pkt_rx_mod  (pkt_rx_mod),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_err     (out_err),
        .out_mod     (out_mod),
        .out_val     (out_val),
        .out_ready   (out_ready),
        .pkt_len     (pkt_len),
        .pkt_status  (pkt_status),
        .pkt_len_val (pkt_len_val),
        .good_pkt_cnt(good_pkt_cnt),
        .bad_pkt_cnt (bad_pkt_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef struct packed {
        logic [15:0] len;
        logic [3:0]  status;
        logic [3:0]  mask;
        logic        bad;
    } rpt_t;

    word_t mac_q[$];
    word_t exp_q[$];
    rpt_t  rpt_q[$];

    int tests = 0;
    int fails = 0;
    logic [CNT_W-1:0] exp_good = '0;
    logic [CNT_W-1:0] exp_bad  = '0;

    int ren_hi_cnt = 0;
    int low_run    = 0;
    int min_gap    = 1000;
    bit seen_hi    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue one packet for the MAC and its expected stream words and report.
    task automatic send_pkt(input int nbytes, input bit mac_err, input bit no_sop);
        int    nw;
        bit    frm, size;
        word_t w, e;
        rpt_t  r;
        nw   = (nbytes + 7) / 8;
        frm  = no_sop;
        size = (nbytes < 64) || (nbytes > 1518);
        for (int i = 0; i < nw; i++) begin
            w.data = {$urandom, $urandom};
            w.sop  = (i == 0) && !no_sop;
            w.eop  = (i == nw - 1);
            w.mod  = w.eop ? 3'(nbytes % 8) : 3'd0;
            w.err  = w.eop && mac_err;
            mac_q.push_back(w);
            e     = w;
            e.err = w.eop && (mac_err || frm || size);
            exp_q.push_back(e);
        end
        r.len    = 16'(nbytes);
        r.status = {1'b0, frm, size, mac_err};
        r.mask   = 4'hF;
        r.bad    = mac_err || frm || size;
        rpt_q.push_back(r);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rpt_q.size() != 0 || mac_q.size() != 0) && n < 3000) begin
            @(posedge clk_156m25);
            n++;
        end
        chk(tag, 64'(exp_q.size() + rpt_q.size() + mac_q.size()), 64'd0);
        repeat (3) @(posedge clk_156m25);
        #2;
    endtask

    // MAC model: a word requested in one cycle appears on pkt_rx_* in the next.
    initial begin
        logic  r;
        word_t w;
        pkt_rx_avail = 1'b0;
        pkt_rx_val   = 1'b0;
        pkt_rx_data  = 64'd0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_err   = 1'b0;
        pkt_rx_mod   = 3'd0;
        forever begin
            @(negedge clk_156m25);
            r = pkt_rx_ren;
            if (r) begin
                ren_hi_cnt++;
                if (seen_hi && low_run > 0 && low_run < min_gap) min_gap = low_run;
                low_run = 0;
                seen_hi = 1'b1;
            end else begin
                low_run++;
            end
            @(posedge clk_156m25);
            #1;
            if (r && mac_q.size() > 0) begin
                w           = mac_q.pop_front();
                pkt_rx_val  = 1'b1;
                pkt_rx_data = w.data;
                pkt_rx_sop  = w.sop;
                pkt_rx_eop  = w.eop;
                pkt_rx_mod  = w.mod;
                pkt_rx_err  = w.err;
            end else begin
                pkt_rx_val  = 1'b0;
                pkt_rx_data = 64'd0;
                pkt_rx_sop  = 1'b0;
                pkt_rx_eop  = 1'b0;
                pkt_rx_mod  = 3'd0;
                pkt_rx_err  = 1'b0;
            end
            pkt_rx_avail = (mac_q.size() > 0);
        end
    end

    // Output and report monitor
    initial begin
        word_t e;
        rpt_t  r;
        forever begin
            @(negedge clk_156m25);
            if (!reset_156m25 && out_val && out_ready) begin
                chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_sop", 64'(out_sop), 64'(e.sop));
                    chk("out_eop", 64'(out_eop), 64'(e.eop));
                    chk("out_mod", 64'(out_mod), 64'(e.mod));
                    if (e.eop) chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
            if (!reset_156m25 && pkt_len_val) begin
                chk("report_expected", 64'(rpt_q.size() != 0), 64'd1);
                if (rpt_q.size() != 0) begin
                    r = rpt_q.pop_front();
                    if (r.bad) exp_bad = exp_bad + 1'b1;
                    else       exp_good = exp_good + 1'b1;
                    chk("pkt_len", 64'(pkt_len), 64'(r.len));
                    chk("pkt_status", 64'(pkt_status & r.mask), 64'(r.status & r.mask));
                    chk("good_pkt_cnt", 64'(good_pkt_cnt), 64'(exp_good));
                    chk("bad_pkt_cnt", 64'(bad_pkt_cnt), 64'(exp_bad));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, tests=%0d", tests);
        $fatal(1, "global timeout");
    end

    initial begin
        reset_156m25 = 1'b1;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk_156m25);
        #2;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_ren", 64'(pkt_rx_ren), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_pkt_len", 64'(pkt_len), 64'd0);
        chk("rst_pkt_status", 64'(pkt_status), 64'd0);
        chk("rst_pkt_len_val", 64'(pkt_len_val), 64'd0);
        chk("rst_good", 64'(good_pkt_cnt), 64'd0);
        chk("rst_bad", 64'(bad_pkt_cnt), 64'd0);
        reset_156m25 = 1'b0;
        @(posedge clk_156m25);
        #2;

        // 64-byte good packet
        ren_hi_cnt = 0;
        send_pkt(64, 1'b0, 1'b0);
        wait_drain("t1_drain");
        chk("t1_ren_cycles", 64'(ren_hi_cnt), 64'd8);
        chk("t1_good", 64'(good_pkt_cnt), 64'd1);
        chk("t1_len", 64'(pkt_len), 64'd64);

        // 67-byte packet with downstream stall mid-packet
        send_pkt(67, 1'b0, 1'b0);
        repeat (4) @(posedge clk_156m25);
        #2;
        out_ready = 1'b0;
        repeat (10) @(posedge clk_156m25);
        #2;
        out_ready = 1'b1;
        wait_drain("t2_drain");
        chk("t2_len", 64'(pkt_len), 64'd67);
        chk("t2_good", 64'(good_pkt_cnt), 64'd2);

        // runt then giant
        send_pkt(40, 1'b0, 1'b0);
        send_pkt(1600, 1'b0, 1'b0);
        wait_drain("t3_drain");
        chk("t3_len", 64'(pkt_len), 64'd1600);
        chk("t3_status", 64'(pkt_status), 64'h2);
        chk("t3_bad", 64'(bad_pkt_cnt), 64'd2);

        // MAC error on eop
        send_pkt(128, 1'b1, 1'b0);
        wait_drain("t4_drain");
        chk("t4_status", 64'(pkt_status), 64'h1);
        chk("t4_bad", 64'(bad_pkt_cnt), 64'd3);

        // missing sop, back-to-back with avail held high
        min_gap = 1000;
        seen_hi = 1'b0;
        low_run = 0;
        send_pkt(64, 1'b0, 1'b1);
        send_pkt(72, 1'b0, 1'b0);
        wait_drain("t5_drain");
        chk("t5_gap", 64'(min_gap >= 2 && min_gap < 1000), 64'd1);
        chk("t5_bad", 64'(bad_pkt_cnt), 64'd4);
        chk("t5_good", 64'(good_pkt_cnt), 64'd3);

        // reset mid-packet
        out_ready = 1'b0;
        send_pkt(128, 1'b0, 1'b0);
        repeat (6) @(posedge clk_156m25);
        #2;
        chk("t6_pre_val", 64'(out_val), 64'd1);
        reset_156m25 = 1'b1;
        #1;
        chk("t6_out_val", 64'(out_val), 64'd0);
        chk("t6_ren", 64'(pkt_rx_ren), 64'd0);
        chk("t6_out_data", out_data, 64'd0);
        chk("t6_out_flags", 64'({out_sop, out_eop, out_err, out_mod}), 64'd0);
        chk("t6_pkt_len", 64'(pkt_len), 64'd0);
        chk("t6_pkt_status", 64'(pkt_status), 64'd0);
        chk("t6_len_val", 64'(pkt_len_val), 64'd0);
        chk("t6_good", 64'(good_pkt_cnt), 64'd0);
        chk("t6_bad", 64'(bad_pkt_cnt), 64'd0);
        mac_q.delete();
        exp_q.delete();
        rpt_q.delete();
        exp_good = '0;
        exp_bad  = '0;
        repeat (3) @(posedge clk_156m25);
        #2;
        reset_156m25 = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk_156m25);
        #2;
        send_pkt(64, 1'b0, 1'b0);
        wait_drain("t6_post_drain");
        chk("t6_post_good", 64'(good_pkt_cnt), 64'd1);
        chk("t6_post_bad", 64'(bad_pkt_cnt), 64'd0);

`ifdef E_RX_TIMEOUT_EN
        // MAC stalls after three words: expect a terminator word
        begin
            word_t w;
            rpt_t  r;
            for (int i = 0; i < 3; i++) begin
                w.data = {$urandom, $urandom};
                w.sop  = (i == 0);
                w.eop  = 1'b0;
                w.mod  = 3'd0;
                w.err  = 1'b0;
                mac_q.push_back(w);
                exp_q.push_back(w);
            end
            w = '{data: 64'd0, sop: 1'b0, eop: 1'b1, mod: 3'd0, err: 1'b1};
            exp_q.push_back(w);
            r = '{len: 16'd24, status: 4'b1000, mask: 4'b1000, bad: 1'b1};
            rpt_q.push_back(r);
            wait_drain("t7_drain");
            chk("t7_len", 64'(pkt_len), 64'd24);
            chk("t7_timeout_bit", 64'(pkt_status[3]), 64'd1);
            chk("t7_bad", 64'(bad_pkt_cnt), 64'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e_rx_pkt_reader.md
Name: e_rx_pkt_reader

Overview:
- Receive-side counterpart of the MAC TX packet interface in the 10GE environment, running in the 156.25 MHz domain.
- Drains packets from the MAC RX packet interface (avail/ren handshake, 1-cycle read latency) into a 4-entry skid FIFO.
- Presents packets on a valid/ready stream.
- Per packet, computes byte length and framing/error status, and keeps saturating good/bad packet counters.

Parameters:
- MIN_PKT_BYTES, 64: packets shorter than this are runts.
- MAX_PKT_BYTES, 1518: packets longer than this are giants.
- CNT_W, 32: width of statistics counters.
- TIMEOUT_CYC, 256: watchdog limit. Used only with E_RX_TIMEOUT_EN.

Ports:
- clk_156m25  in  1  sole clock, all logic on posedge.
- reset_156m25  in  1  asynchronous, active-high reset.
- pkt_rx_avail  in  1  MAC has at least one complete packet.
- pkt_rx_ren  out  1  read enable to MAC; the word appears on pkt_rx_* the next cycle.
- pkt_rx_data  in  64  MAC data.
- pkt_rx_sop / pkt_rx_eop / pkt_rx_val / pkt_rx_err  in  1 each  MAC framing, valid and error (err meaningful on eop).
- pkt_rx_mod  in  3  valid bytes in eop word; 0 means 8.
- out_data  out  64  stream data.
- out_sop / out_eop / out_err  out  1 each  stream framing; out_err is qualified by out_eop.
- out_mod  out  3  same encoding as pkt_rx_mod.
- out_val  out  1  stream valid.
- out_ready  in  1  downstream accept.
- pkt_len  out  16  byte length of last packet, saturating at 0xFFFF.
- pkt_status  out  4  {timeout, framing, giant_or_runt, mac_err} of last packet.
- pkt_len_val  out  1  1-cycle pulse when pkt_len/pkt_status update.
- good_pkt_cnt / bad_pkt_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Reset: all outputs 0. FSM=IDLE, FIFO empty, counters 0.
- FSM states:
  - IDLE -> RD when pkt_rx_avail=1.
  - RD -> GAP on cycle with pkt_rx_val & pkt_rx_eop.
  - GAP -> IDLE after exactly 1 cycle. GAP masks stale avail after MAC updates.
- Read enable:
  - pkt_rx_ren = (state==RD) & !(pkt_rx_val & pkt_rx_eop) & (fifo_cnt + ren_d1 <= 2), where ren_d1 is ren registered.
  - This guarantees the FIFO never overflows with one read in flight.
- Capture: every pkt_rx_val=1 cycle pushes {data, sop, eop, mod, err_flag} into the FIFO. pkt_rx_val while not in RD is ignored.
- FIFO:
  - 4 entries, first-word-fall-through.
  - out_val = !empty; pop on out_val & out_ready.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - out_data holds stable while out_val=1 & out_ready=0.
- Length:
  - Running len = 8 per non-eop word; eop word adds (mod==0 ? 8 : mod).
  - 16-bit, saturating at 0xFFFF.
  - Cleared on first word of each packet.
- Framing error:
  - First valid word in RD lacking sop, or any sop after the first word.
  - Words are still passed through; sop is forwarded as received.
- err_flag on eop word = mac_err | framing | (len<MIN_PKT_BYTES) | (len>MAX_PKT_BYTES). It drives out_err.
- Reporting: the cycle after eop capture, pulse pkt_len_val; load pkt_len and pkt_status; increment good_pkt_cnt if err_flag=0, else bad_pkt_cnt. Counters saturate at all-ones.
- Reset mid-packet: immediate return to IDLE, FIFO flushed, ren=0. No partial report.

Optional Feature:
- Macro E_RX_TIMEOUT_EN.
- Enabled:
  - A watchdog counts consecutive RD cycles without pkt_rx_val, clearing on each valid word.
  - At TIMEOUT_CYC, ren drops and FSM enters ABORT.
  - ABORT waits until fifo_cnt<4, then pushes terminator {data=0, eop=1, mod=0, err=1} and goes to GAP.
  - Reporting: pkt_status[3]=1, bad_pkt_cnt increments, pkt_len = bytes so far.
- Disabled: no watchdog or ABORT state; pkt_status[3] tied 0.

Test Plan:
- 64-byte packet (8 words, mod=0, out_ready=1): ren high 8 cycles, 8 words out in order, pkt_len=64, status=0, good_pkt_cnt=1.
- 67-byte packet (eop mod=3) with out_ready held 0 for 10 cycles mid-packet: fifo_cnt never exceeds 4, no word lost or duplicated, pkt_len=67.
- 40-byte runt, then 1600-byte giant: both out_err=1 on eop, status[1]=1, bad_pkt_cnt=2, pkt_len=40 then 1600.
- pkt_rx_err=1 on eop of a 128-byte packet: status=4'b0001, out_err=1, bad_pkt_cnt increments.
- Missing sop on first word, back-to-back packets with avail held high: framing bit set, GAP cycle observed (ren=0 for at least 2 cycles between packets).
- E_RX_TIMEOUT_EN: MAC stalls val after 3 words for 256 cycles: terminator word emitted with eop=1, err=1, pkt_len=24, status[3]=1. Separately, reset asserted mid-packet: all outputs 0 next cycle.
